serial_io_controller: RTL and testbench

//  Buffers and sequences the processor's byte-wide serial port (cpu_* side) onto a UART byte engine (uart_* side).
//  TX FIFO absorbs processor writes and a drain FSM hands bytes to the UART one at a time.
//  RX FIFO captures UART receive strobes and presents them as first-word-fall-through to the processor.

---
 rtl/serial_io_controller.sv | 188 ++++++++++++++++++
 tb/tb_serial_io_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_controller.sv
// Serial I/O controller: a TX FIFO drained onto a UART byte engine by a three-state
// handshake FSM, plus a first-word-fall-through RX FIFO filled from UART receive strobes.
module serial_io_controller #(
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    output logic       cpu_ready_out,
    input  logic [7:0] uart_rx_data_in,
    input  logic       uart_rx_strobe_in,
    input  logic       uart_tx_busy_in,
    output logic [7:0] uart_tx_data_out,
    output logic       uart_tx_start_out,
    output logic       tx_overflow_out,
    output logic       rx_overflow_out,
    input  logic       clear_flags_in
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

    tx_state_e         tx_state_q, tx_state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;

    logic [7:0]        tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_CW-1:0]  tx_count_q, tx_count_d;
    logic [7:0]        rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_CW-1:0]  rx_count_q, rx_count_d;
    logic              tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

    logic tx_full_s, tx_push_s, tx_pop_s, tx_ovf_evt_s, tx_launch_s;
    logic rx_full_s, rx_empty_s, rx_push_s, rx_pop_s, rx_ovf_evt_s;

    assign tx_full_s   = (tx_count_q == TX_CW'(TX_DEPTH));
    assign rx_full_s   = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_empty_s  = (rx_count_q == RX_CW'(0));
    assign tx_launch_s = (tx_state_q == TX_IDLE) && (tx_count_q != TX_CW'(0)) && !uart_tx_busy_in;

    assign cpu_ready_out     = ~tx_full_s;
    assign cpu_valid_out     = ~rx_empty_s;
    assign cpu_data_out      = rx_empty_s ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
    assign uart_tx_data_out  = tx_data_q;
    assign uart_tx_start_out = tx_start_q;
    assign tx_overflow_out   = tx_ovf_q;
    assign rx_overflow_out   = rx_ovf_q;

    // FSM state, timeout counter and registered UART-side outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            to_cnt_q   <= TO_W'(0);
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            to_cnt_q   <= to_cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // FSM next-state; an unanswered start gives up after BUSY_TIMEOUT cycles
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_launch_s) tx_state_d = TX_WAIT_BUSY;
                else             tx_state_d = TX_IDLE;
            end
            TX_WAIT_BUSY: begin
                if (uart_tx_busy_in)                                   tx_state_d = TX_WAIT_DONE;
                else if ((to_cnt_q + TO_W'(1)) == TO_W'(BUSY_TIMEOUT)) tx_state_d = TX_IDLE;
                else                                                   tx_state_d = TX_WAIT_BUSY;
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy_in) tx_state_d = TX_IDLE;
                else                  tx_state_d = TX_WAIT_DONE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // FSM outputs: launch pops the head into the holding register with a start pulse
    always_comb begin
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        to_cnt_d   = to_cnt_q;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_launch_s) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_mem_q[tx_rd_ptr_q];
                    to_cnt_d   = TO_W'(0);
                    tx_pop_s   = 1'b1;
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            TX_WAIT_BUSY: begin
                if (!uart_tx_busy_in) to_cnt_d = to_cnt_q + TO_W'(1);
                else                  to_cnt_d = to_cnt_q;
            end
            TX_WAIT_DONE: to_cnt_d = to_cnt_q;
            default:      to_cnt_d = TO_W'(0);
        endcase
    end

    // FIFO pointer/count and sticky flag next-state
    always_comb begin
        tx_push_s    = cpu_wren_in & ~tx_full_s;
        tx_ovf_evt_s = cpu_wren_in & tx_full_s;
        rx_pop_s     = cpu_rden_in & ~rx_empty_s;
        // a pop in the same cycle frees the slot, so a full RX FIFO still accepts
        rx_push_s    = uart_rx_strobe_in & (~rx_full_s | rx_pop_s);
        rx_ovf_evt_s = uart_rx_strobe_in & rx_full_s & ~rx_pop_s;

        tx_wr_ptr_d = tx_push_s ? tx_wr_ptr_q + TX_AW'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop_s  ? tx_rd_ptr_q + TX_AW'(1) : tx_rd_ptr_q;
        rx_wr_ptr_d = rx_push_s ? rx_wr_ptr_q + RX_AW'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop_s  ? rx_rd_ptr_q + RX_AW'(1) : rx_rd_ptr_q;

        if (tx_push_s && !tx_pop_s)      tx_count_d = tx_count_q + TX_CW'(1);
        else if (!tx_push_s && tx_pop_s) tx_count_d = tx_count_q - TX_CW'(1);
        else                             tx_count_d = tx_count_q;

        if (rx_push_s && !rx_pop_s)      rx_count_d = rx_count_q + RX_CW'(1);
        else if (!rx_push_s && rx_pop_s) rx_count_d = rx_count_q - RX_CW'(1);
        else                             rx_count_d = rx_count_q;

        if (clear_flags_in) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end else begin
            tx_ovf_d = tx_ovf_q | tx_ovf_evt_s;
            rx_ovf_d = rx_ovf_q | rx_ovf_evt_s;
        end
    end

    // FIFO pointers, counts and sticky flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_q <= TX_AW'(0);
            tx_rd_ptr_q <= TX_AW'(0);
            tx_count_q  <= TX_CW'(0);
            rx_wr_ptr_q <= RX_AW'(0);
            rx_rd_ptr_q <= RX_AW'(0);
            rx_count_q  <= RX_CW'(0);
            tx_ovf_q    <= 1'b0;
            rx_ovf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    // FIFO storage; contents are only observable through the counted pointers
    always_ff @(posedge clock) begin
        if (tx_push_s) tx_mem_q[tx_wr_ptr_q] <= cpu_data_in;
        if (rx_push_s) rx_mem_q[rx_wr_ptr_q] <= uart_rx_data_in;
    end

endmodule

// File: tb/tb_serial_io_controller.sv
// Randomized self-checking bench for serial_io_controller: a queue-based transaction
// model predicts every output each cycle, with directed literal checks pinning the model.
`timescale 1ns/1ps
module tb_serial_io_controller;
    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam int TO  = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] cpu_data_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_rden_in = 1'b0;
    logic [7:0] cpu_data_out;
    logic       cpu_valid_out, cpu_ready_out;
    logic [7:0] uart_rx_data_in = 8'h00;
    logic       uart_rx_strobe_in = 1'b0;
    logic       uart_tx_busy_in = 1'b0;
    logic [7:0] uart_tx_data_out;
    logic       uart_tx_start_out, tx_overflow_out, rx_overflow_out;
    logic       clear_flags_in = 1'b0;

    int checks = 0;
    int errors = 0;

    // UART emulation: 0 = never busy, 1 = busy after each start, 2 = busy forever
    int uart_mode = 1;
    int busy_len  = 0;
    int busy_left = 0;

    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    bit         m_in_flight = 1'b0;
    bit         m_busy_seen = 1'b0;
    int         m_waited = 0;
    logic       m_start = 1'b0;
    logic [7:0] m_txdata = 8'h00;
    logic       m_txovf = 1'b0;
    logic       m_rxovf = 1'b0;
    bit         m_tx_full, m_rx_full, m_rx_popped;

    serial_io_controller #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .BUSY_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .cpu_data_in(cpu_data_in), .cpu_wren_in(cpu_wren_in), .cpu_rden_in(cpu_rden_in),
        .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out), .cpu_ready_out(cpu_ready_out),
        .uart_rx_data_in(uart_rx_data_in), .uart_rx_strobe_in(uart_rx_strobe_in),
        .uart_tx_busy_in(uart_tx_busy_in), .uart_tx_data_out(uart_tx_data_out),
        .uart_tx_start_out(uart_tx_start_out), .tx_overflow_out(tx_overflow_out),
        .rx_overflow_out(rx_overflow_out), .clear_flags_in(clear_flags_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: updated on each rising edge from the inputs seen there
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_txq.delete();
            m_rxq.delete();
            m_in_flight = 1'b0;
            m_busy_seen = 1'b0;
            m_waited    = 0;
            m_start     = 1'b0;
            m_txdata    = 8'h00;
            m_txovf     = 1'b0;
            m_rxovf     = 1'b0;
        end else begin
            m_tx_full   = (m_txq.size() == TXD);
            m_rx_full   = (m_rxq.size() == RXD);
            m_rx_popped = 1'b0;
            m_start     = 1'b0;
            if (!m_in_flight) begin
                if (m_txq.size() != 0 && !uart_tx_busy_in) begin
                    m_txdata    = m_txq.pop_front();
                    m_start     = 1'b1;
                    m_in_flight = 1'b1;
                    m_busy_seen = 1'b0;
                    m_waited    = 0;
                end
            end else if (!m_busy_seen) begin
                if (uart_tx_busy_in) m_busy_seen = 1'b1;
                else begin
                    m_waited++;
                    if (m_waited == TO) m_in_flight = 1'b0;
                end
            end else if (!uart_tx_busy_in) begin
                m_in_flight = 1'b0;
            end
            if (cpu_wren_in && !m_tx_full) m_txq.push_back(cpu_data_in);
            if (cpu_rden_in && m_rxq.size() != 0) begin
                void'(m_rxq.pop_front());
                m_rx_popped = 1'b1;
            end
            if (uart_rx_strobe_in && (!m_rx_full || m_rx_popped)) m_rxq.push_back(uart_rx_data_in);
            if (clear_flags_in) begin
                m_txovf = 1'b0;
                m_rxovf = 1'b0;
            end else begin
                if (cpu_wren_in && m_tx_full) m_txovf = 1'b1;
                if (uart_rx_strobe_in && m_rx_full && !m_rx_popped) m_rxovf = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clock);
        chk("valid",   32'(cpu_valid_out),     32'(m_rxq.size() != 0));
        chk("rdata",   32'(cpu_data_out),      32'((m_rxq.size() != 0) ? m_rxq[0] : 8'h00));
        chk("ready",   32'(cpu_ready_out),     32'(m_txq.size() != TXD));
        chk("start",   32'(uart_tx_start_out), 32'(m_start));
        chk("tx_data", 32'(uart_tx_data_out),  32'(m_txdata));
        chk("tx_ovf",  32'(tx_overflow_out),   32'(m_txovf));
        chk("rx_ovf",  32'(rx_overflow_out),   32'(m_rxovf));
    end

    // UART responder driving busy in reaction to start pulses
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            busy_left       = 0;
            uart_tx_busy_in = 1'b0;
        end else if (uart_mode == 2) begin
            uart_tx_busy_in = 1'b1;
        end else begin
            if (uart_mode == 1 && uart_tx_start_out && busy_left == 0)
                busy_left = (busy_len != 0) ? busy_len : int'($urandom_range(1, 12));
            if (busy_left > 0) begin
                uart_tx_busy_in = 1'b1;
                busy_left--;
            end else begin
                uart_tx_busy_in = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [7:0] b);
        cpu_data_in = b;
        cpu_wren_in = 1'b1;
        @(negedge clock);
        cpu_wren_in = 1'b0;
    endtask

    task automatic rx_put(input logic [7:0] b, input logic rd);
        uart_rx_data_in   = b;
        uart_rx_strobe_in = 1'b1;
        cpu_rden_in       = rd;
        @(negedge clock);
        uart_rx_strobe_in = 1'b0;
        cpu_rden_in       = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] v);
        chk(name, 32'(cpu_data_out), 32'(v));
        cpu_rden_in = 1'b1;
        @(negedge clock);
        cpu_rden_in = 1'b0;
    endtask

    task automatic clear_flags();
        clear_flags_in = 1'b1;
        @(negedge clock);
        clear_flags_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((m_txq.size() != 0 || m_in_flight) && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("drain_bound", 32'(n < budget), 32'(1));
    endtask

    initial begin
        int gap;
        cyc(2);
        chk("rst_ready",  32'(cpu_ready_out),     32'(1));
        chk("rst_valid",  32'(cpu_valid_out),     32'(0));
        chk("rst_rdata",  32'(cpu_data_out),      32'(0));
        chk("rst_start",  32'(uart_tx_start_out), 32'(0));
        chk("rst_txdata", 32'(uart_tx_data_out),  32'(0));
        reset = 1'b1;
        cyc(2);

        // single byte: start two cycles after the write, 10-cycle busy
        uart_mode = 1;
        busy_len  = 10;
        wr(8'h41);
        chk("t1_no_early_start", 32'(uart_tx_start_out), 32'(0));
        cyc(1);
        chk("t1_start", 32'(uart_tx_start_out), 32'(1));
        chk("t1_data",  32'(uart_tx_data_out),  32'(8'h41));
        cyc(14);
        wr(8'h42);
        cyc(1);
        chk("t1_idle_restart", 32'(uart_tx_start_out), 32'(1));
        chk("t1_data2",        32'(uart_tx_data_out),  32'(8'h42));
        cyc(14);

        // fill TX with the UART held busy
        uart_mode = 2;
        cyc(2);
        for (int i = 0; i < TXD; i++) wr(8'(i + 8'h80));
        chk("t2_full_ready", 32'(cpu_ready_out), 32'(0));
        wr(8'hFF);
        chk("t2_ovf_set", 32'(tx_overflow_out), 32'(1));
        clear_flags();
        chk("t2_ovf_clr", 32'(tx_overflow_out), 32'(0));
        uart_mode = 1;
        busy_len  = 0;
        wait_drain(1000);

        // RX ordering and first-word-fall-through
        rx_put(8'h10, 1'b0);
        chk("t3_valid_lat", 32'(cpu_valid_out), 32'(1));
        rx_put(8'h11, 1'b0);
        rx_put(8'h12, 1'b0);
        pop_expect("t3_pop0", 8'h10);
        pop_expect("t3_pop1", 8'h11);
        pop_expect("t3_pop2", 8'h12);
        chk("t3_empty", 32'(cpu_valid_out), 32'(0));
        cpu_rden_in = 1'b1;
        cyc(1);
        cpu_rden_in = 1'b0;
        chk("t3_extra_rd", 32'(cpu_valid_out), 32'(0));

        // RX full: simultaneous push/pop, then drop
        for (int i = 0; i < RXD; i++) rx_put(8'(i + 8'h20), 1'b0);
        rx_put(8'h99, 1'b1);
        chk("t4_no_ovf", 32'(rx_overflow_out), 32'(0));
        rx_put(8'hAA, 1'b0);
        chk("t4_ovf", 32'(rx_overflow_out), 32'(1));
        for (int i = 0; i < RXD - 1; i++) pop_expect("t4_pop", 8'(i + 8'h21));
        pop_expect("t4_last", 8'h99);
        chk("t4_empty", 32'(cpu_valid_out), 32'(0));
        clear_flags();

        // UART never answers: handshake abandoned after the timeout
        uart_mode = 0;
        cyc(2);
        wr(8'h51);
        wr(8'h52);
        chk("t5_start1", 32'(uart_tx_start_out), 32'(1));
        chk("t5_data1",  32'(uart_tx_data_out),  32'(8'h51));
        gap = 0;
        do begin
            cyc(1);
            gap++;
        end while (!uart_tx_start_out && gap < 40);
        chk("t5_gap",   32'(gap),              32'(TO + 1));
        chk("t5_data2", 32'(uart_tx_data_out), 32'(8'h52));
        wait_drain(100);

        // reset while waiting for the UART to finish, with bytes queued
        uart_mode = 1;
        busy_len  = 40;
        rx_put(8'h77, 1'b0);
        for (int i = 0; i < 6; i++) wr(8'(i + 8'h60));
        cyc(3);
        #2 reset = 1'b0;
        #1;
        chk("t6_ready",  32'(cpu_ready_out),     32'(1));
        chk("t6_valid",  32'(cpu_valid_out),     32'(0));
        chk("t6_rdata",  32'(cpu_data_out),      32'(0));
        chk("t6_start",  32'(uart_tx_start_out), 32'(0));
        chk("t6_txdata", 32'(uart_tx_data_out),  32'(0));
        cyc(3);
        reset = 1'b1;
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("t6_no_start", 32'(uart_tx_start_out), 32'(0));
            chk("t6_no_valid", 32'(cpu_valid_out),     32'(0));
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 9))
                    0:       uart_mode = 0;
                    1:       uart_mode = 2;
                    default: uart_mode = 1;
                endcase
            end
            cpu_wren_in       = ($urandom % 3) == 0;
            cpu_data_in       = 8'($urandom);
            cpu_rden_in       = ($urandom % 3) == 0;
            uart_rx_strobe_in = ($urandom % 3) == 0;
            uart_rx_data_in   = 8'($urandom);
            clear_flags_in    = ($urandom % 50) == 0;
            cyc(1);
        end
        cpu_wren_in       = 1'b0;
        cpu_rden_in       = 1'b0;
        uart_rx_strobe_in = 1'b0;
        clear_flags_in    = 1'b0;
        uart_mode         = 1;
        wait_drain(2000);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
